fft_stage_sequencer: RTL and testbench
======================================

// Module: fft_stage_sequencer
// PURPOSE
// Sequencer for one radix-2 in-place DIT FFT of N=2^LOG2N points, driving a single shared butterfly
// (x_N, x_M, w_N -> y_N, y_M; fixed BFLY_LAT pipeline) and a dual-port data RAM plus twiddle ROM.
// Issues one butterfly per cycle: read addresses, twiddle index, then matching write-back addresses
// delayed by the full read + butterfly latency. Drains between stages so stage s+1 never reads stale data.
// PARAMETERS
// LOG2N     4  log2 of FFT size N (N=16); legal 2..12
// RD_LAT    1  data RAM / twiddle ROM read latency, cycles
// BFLY_LAT  2  butterfly latency, cycles (input reg + output reg)
// PORTS
// clk        in   1        clock, all logic on rising edge
// rst_n      in   1        asynchronous active-low reset
// start      in   1        begin FFT; sampled in IDLE only
// abort      in   1        synchronous abort; kills run and all pending writes
// busy       out  1        high from cycle after accepted start until done
// done       out  1        one-cycle pulse, final write-back committed
// stage      out  LOG2N'   current stage index s, 0..LOG2N-1 (width clog2(LOG2N), min 1)
// rd_en      out  1        read/issue strobe for RAM and ROM
// rd_addr_a  out  LOG2N    RAM address feeding x_N
// rd_addr_b  out  LOG2N    RAM address feeding x_M
// tw_addr    out  LOG2N-1  twiddle ROM index feeding w_N
// wr_en      out  1        write-back strobe (y_N -> wr_addr_a, y_M -> wr_addr_b)
// wr_addr_a  out  LOG2N    write address for y_N
// wr_addr_b  out  LOG2N    write address for y_M
// BEHAVIOUR
// - Reset (rst_n=0, async): state=IDLE; every output 0; issue/drain counters and write pipeline cleared.
// - FSM: IDLE -start-> RUN; RUN -(k==N/2-1)-> DRAIN; DRAIN -(D cycles, s<LOG2N-1)-> RUN with s+1, k=0;
//   DRAIN -(D cycles, s==LOG2N-1)-> DONE; DONE -> IDLE (1 cycle, done=1). D = RD_LAT+BFLY_LAT.
// - RUN: rd_en=1 every cycle; k counts 0..N/2-1. span=1<<s, pos=k&(span-1), grp=k>>s:
//   rd_addr_a=(grp<<(s+1))|pos; rd_addr_b=rd_addr_a+span; tw_addr=pos<<(LOG2N-1-s). Addr registered.
// - Write-back: {valid,addr_a,addr_b} shift pipeline of depth D; wr_en/wr_addr_* = rd_en/rd_addr_*
//   exactly D cycles later. Latency constant, no stalls; pipeline shifts every cycle in every state.
// - DRAIN: rd_en=0 for exactly D cycles; last wr_en of stage s lands in last DRAIN cycle;
//   first read of stage s+1 is the following cycle (RAM write-before-read not required).
// - busy=1 in RUN, DRAIN; 0 in IDLE and DONE. stage holds its value until next start, reset to 0 on start.
// - start while busy: ignored. start in DONE cycle: ignored (accepted next cycle in IDLE).
// - abort in any state: next state IDLE, rd_en=0, write pipeline valids cleared same edge (no later wr_en),
//   done not asserted. abort and start same cycle in IDLE: abort wins, stays IDLE.
// - Counts per FFT: N/2*LOG2N rd_en and wr_en pulses; total cycles start->done = LOG2N*(N/2+D)+1.
// - All address arithmetic unsigned, modulo 2^LOG2N; no overflow possible for legal k, s.
// TESTING
// 1 Reset: hold rst_n=0 mid-RUN, release -> all outputs 0, IDLE, no wr_en for >=10 cycles.
// 2 N=16 defaults, start at cycle 0 -> rd_en cycles 1-8 stage0: (a,b,tw)=(0,1,0),(2,3,0)..(14,15,0);
//   stage1 k=1 -> (1,3,4); stage3 k=7 -> (7,15,7); done pulse at cycle 45; 32 rd_en, 32 wr_en.
// 3 Write-back check: every wr_en/wr_addr_a/b equals rd_en/rd_addr_a/b delayed exactly 3 cycles;
//   no rd_en in stage s+1 before last wr_en of stage s (scoreboard + bit-exact FFT vs. model).
// 4 abort at stage 2 k=3 -> next cycle IDLE, busy=0, zero further wr_en, no done; new start runs clean.
// 5 start pulsed during RUN and in DONE cycle -> ignored; start+abort in IDLE -> stays IDLE.
// 6 LOG2N=3, RD_LAT=2 -> D=4, stage2 issues (0,4,0)..(3,7,3), done at cycle 3*(4+4)+1=25.

Source files
------------

// File: rtl/fft_stage_sequencer.sv
// Issue/write-back sequencer for an in-place radix-2 DIT FFT on one shared butterfly.
// One butterfly is issued per cycle; write-backs trail reads by the read plus butterfly latency.
module fft_stage_sequencer #(
  parameter int LOG2N    = 4,
  parameter int RD_LAT   = 1,
  parameter int BFLY_LAT = 2,
  localparam int SW      = (LOG2N > 2) ? $clog2(LOG2N) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic [SW-1:0]    stage,
  output logic             rd_en,
  output logic [LOG2N-1:0] rd_addr_a,
  output logic [LOG2N-1:0] rd_addr_b,
  output logic [LOG2N-2:0] tw_addr,
  output logic             wr_en,
  output logic [LOG2N-1:0] wr_addr_a,
  output logic [LOG2N-1:0] wr_addr_b
);

  localparam int D  = RD_LAT + BFLY_LAT;
  localparam int CW = $clog2(D + 1);
  localparam logic [LOG2N-2:0] K_LAST = '1;
  localparam logic [SW-1:0]    S_LAST = SW'(LOG2N - 1);
  localparam logic [CW-1:0]    C_LAST = CW'(D - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t           state_q, state_d;
  logic [LOG2N-2:0] k_q, k_d;
  logic [SW-1:0]    s_q, s_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             issue_d;
  logic [LOG2N-1:0] addr_a_d, addr_b_d;
  logic [LOG2N-2:0] tw_d;
  int               kk, ss, pos, base;

  logic [D-1:0]     vld_pipe;
  logic [LOG2N-1:0] a_pipe [D];
  logic [LOG2N-1:0] b_pipe [D];

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    s_d     = s_q;
    cnt_d   = cnt_q;
    if (abort) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_d = RUN;
            k_d     = '0;
            s_d     = '0;
          end
        end
        RUN: begin
          if (k_q == K_LAST) begin
            state_d = DRAIN;
            cnt_d   = '0;
          end else begin
            k_d = k_q + 1'b1;
          end
        end
        DRAIN: begin
          if (cnt_q == C_LAST) begin
            k_d = '0;
            if (s_q == S_LAST) begin
              state_d = DONE;
            end else begin
              state_d = RUN;
              s_d     = s_q + 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Addresses are computed from the next-cycle k/s so they can be registered alongside rd_en.
  always_comb begin
    issue_d  = (state_d == RUN);
    kk       = int'(k_d);
    ss       = int'(s_d);
    pos      = kk & ((1 << ss) - 1);
    base     = ((kk >> ss) << (ss + 1)) | pos;
    addr_a_d = '0;
    addr_b_d = '0;
    tw_d     = '0;
    if (issue_d) begin
      addr_a_d = LOG2N'(base);
      addr_b_d = LOG2N'(base + (1 << ss));
      tw_d     = (LOG2N-1)'(pos << (LOG2N - 1 - ss));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      k_q       <= '0;
      s_q       <= '0;
      cnt_q     <= '0;
      rd_en     <= 1'b0;
      rd_addr_a <= '0;
      rd_addr_b <= '0;
      tw_addr   <= '0;
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      s_q       <= s_d;
      cnt_q     <= cnt_d;
      rd_en     <= issue_d;
      rd_addr_a <= addr_a_d;
      rd_addr_b <= addr_b_d;
      tw_addr   <= tw_d;
    end
  end

  // Fixed-latency write-back pipe; abort drops every in-flight write on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      for (int i = 0; i < D; i++) begin
        a_pipe[i] <= '0;
        b_pipe[i] <= '0;
      end
    end else begin
      vld_pipe[0] <= rd_en & ~abort;
      a_pipe[0]   <= rd_addr_a;
      b_pipe[0]   <= rd_addr_b;
      for (int i = 1; i < D; i++) begin
        vld_pipe[i] <= vld_pipe[i-1] & ~abort;
        a_pipe[i]   <= a_pipe[i-1];
        b_pipe[i]   <= b_pipe[i-1];
      end
    end
  end

  assign wr_en     = vld_pipe[D-1];
  assign wr_addr_a = a_pipe[D-1];
  assign wr_addr_b = b_pipe[D-1];
  assign busy      = (state_q == RUN) || (state_q == DRAIN);
  assign done      = (state_q == DONE);
  assign stage     = s_q;

endmodule

// File: tb/tb_fft_stage_sequencer.sv
// Self-checking bench: a negedge monitor emulates RAM plus butterfly from the DUT strobes and
// the results are compared with a textbook nested-loop FFT schedule and randomized data.
module tb_fft_stage_sequencer;

  localparam int LOG2N    = 4;
  localparam int RD_LAT   = 1;
  localparam int BFLY_LAT = 2;
  localparam int N        = 1 << LOG2N;
  localparam int HALF     = N / 2;
  localparam int D        = RD_LAT + BFLY_LAT;
  localparam int SW       = (LOG2N > 2) ? $clog2(LOG2N) : 1;
  localparam int T_RUN    = LOG2N * (HALF + D) + 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic             busy, done, rd_en, wr_en;
  logic [SW-1:0]    stage;
  logic [LOG2N-1:0] rd_addr_a, rd_addr_b, wr_addr_a, wr_addr_b;
  logic [LOG2N-2:0] tw_addr;

  fft_stage_sequencer #(.LOG2N(LOG2N), .RD_LAT(RD_LAT), .BFLY_LAT(BFLY_LAT)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .busy(busy), .done(done), .stage(stage),
    .rd_en(rd_en), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .tw_addr(tw_addr),
    .wr_en(wr_en), .wr_addr_a(wr_addr_a), .wr_addr_b(wr_addr_b)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int compared = 0;
  int mismatched = 0;

  typedef struct { int cyc; int a; int b; int tw; } rd_t;
  typedef struct { int cyc; int a; int b; logic [15:0] yn; logic [15:0] ym; } wr_t;

  rd_t         rd_log[$];
  wr_t         pend[$];
  int          done_log[$];
  int          wr_cnt = 0;
  logic [15:0] mem      [N];
  logic [15:0] init_mem [N];
  int          load_req = 0, load_seen = 0;
  int          flush_req = 0, flush_seen = 0;
  rd_t         mon_r;
  wr_t         mon_w;
  logic [15:0] mon_yn, mon_ym;

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic void bfly(input logic [15:0] x, input logic [15:0] y, input int w,
                               output logic [15:0] yn, output logic [15:0] ym);
    logic [15:0] m;
    m  = 16'(y * 16'(w + 3));
    yn = x + m;
    ym = x - m;
  endfunction

  // Monitor: reads compute butterfly results immediately; writes commit them at the DUT write address.
  always @(negedge clk) begin
    if (flush_req != flush_seen) begin
      pend.delete();
      flush_seen = flush_req;
    end
    if (load_req != load_seen) begin
      for (int i = 0; i < N; i++) mem[i] = init_mem[i];
      load_seen = load_req;
    end
    if (wr_en === 1'b1) begin
      wr_cnt++;
      if (pend.size() == 0) begin
        check_output("stray_wr_en", 32'(wr_en), 0);
      end else begin
        mon_w = pend.pop_front();
        check_output("wr_latency", cyc - mon_w.cyc, D);
        check_output("wr_addr_a", 32'(wr_addr_a), mon_w.a);
        check_output("wr_addr_b", 32'(wr_addr_b), mon_w.b);
        mem[wr_addr_a] = mon_w.yn;
        mem[wr_addr_b] = mon_w.ym;
      end
    end
    if (rd_en === 1'b1) begin
      mon_r.cyc = cyc;
      mon_r.a   = int'(rd_addr_a);
      mon_r.b   = int'(rd_addr_b);
      mon_r.tw  = int'(tw_addr);
      rd_log.push_back(mon_r);
      bfly(mem[rd_addr_a], mem[rd_addr_b], int'(tw_addr), mon_yn, mon_ym);
      mon_w.cyc = cyc;
      mon_w.a   = mon_r.a;
      mon_w.b   = mon_r.b;
      mon_w.yn  = mon_yn;
      mon_w.ym  = mon_ym;
      pend.push_back(mon_w);
    end
    if (done === 1'b1) done_log.push_back(cyc);
  end

  task automatic load_memory();
    for (int i = 0; i < N; i++) init_mem[i] = 16'($urandom);
    load_req++;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_output({tag, "_busy"}, 32'(busy), 0);
    check_output({tag, "_done"}, 32'(done), 0);
    check_output({tag, "_stage"}, 32'(stage), 0);
    check_output({tag, "_rd_en"}, 32'(rd_en), 0);
    check_output({tag, "_rd_addr_a"}, 32'(rd_addr_a), 0);
    check_output({tag, "_rd_addr_b"}, 32'(rd_addr_b), 0);
    check_output({tag, "_tw_addr"}, 32'(tw_addr), 0);
    check_output({tag, "_wr_en"}, 32'(wr_en), 0);
    check_output({tag, "_wr_addr_a"}, 32'(wr_addr_a), 0);
    check_output({tag, "_wr_addr_b"}, 32'(wr_addr_b), 0);
  endtask

  // Reference: classic in-place DIT loop over groups and offsets, plus the issue-cycle schedule.
  task automatic verify_run(input int c0, input int rd0, input int dn0, input int wr0);
    logic [15:0] ref_mem [N];
    int n, span, idx, a, b, tw;
    for (int i = 0; i < N; i++) ref_mem[i] = init_mem[i];
    n = 0;
    check_output("rd_count", rd_log.size() - rd0, HALF * LOG2N);
    for (int s = 0; s < LOG2N; s++) begin
      span = 2 ** s;
      idx  = 0;
      for (int j = 0; j < N; j += 2 * span) begin
        for (int p = 0; p < span; p++) begin
          a  = j + p;
          b  = a + span;
          tw = p * (HALF / span);
          if (rd0 + n < rd_log.size()) begin
            check_output("rd_cycle", rd_log[rd0+n].cyc, c0 + 1 + s * (HALF + D) + idx);
            check_output("rd_addr_a", rd_log[rd0+n].a, a);
            check_output("rd_addr_b", rd_log[rd0+n].b, b);
            check_output("tw_addr", rd_log[rd0+n].tw, tw);
          end
          bfly(ref_mem[a], ref_mem[b], tw, ref_mem[a], ref_mem[b]);
          n++;
          idx++;
        end
      end
    end
    check_output("wr_count", wr_cnt - wr0, HALF * LOG2N);
    check_output("pending_writes", pend.size(), 0);
    check_output("done_count", done_log.size() - dn0, 1);
    if (done_log.size() > dn0) check_output("done_cycle", done_log[dn0], c0 + T_RUN);
    for (int i = 0; i < N; i++) check_output("fft_data", mem[i], ref_mem[i]);
  endtask

  task automatic run_fft(input bit poke_done);
    int c0, rd0, dn0, wr0;
    load_memory();
    rd0 = rd_log.size();
    dn0 = done_log.size();
    wr0 = wr_cnt;
    @(posedge clk); #1;
    start = 1'b1;
    c0 = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    check_output("busy_after_start", 32'(busy), 1);
    check_output("stage_after_start", 32'(stage), 0);
    while (cyc < c0 + T_RUN + 3) begin
      if (cyc == c0 + 1 + HALF + D) check_output("stage_mid", 32'(stage), 1);
      @(posedge clk); #1;
      start = 1'b0;
      if (cyc < c0 + T_RUN && $urandom_range(0, 5) == 0) start = 1'b1;
      if (poke_done && cyc == c0 + T_RUN) start = 1'b1;
      if (cyc == c0 + T_RUN + 1) check_output("busy_after_done", 32'(busy), 0);
      if (cyc == c0 + T_RUN + 2) check_output("rd_en_after_done", 32'(rd_en), 0);
    end
    start = 1'b0;
    check_output("stage_hold", 32'(stage), LOG2N - 1);
    verify_run(c0, rd0, dn0, wr0);
  endtask

  task automatic abort_run();
    int c0, dn0, wr0, target, k, span;
    load_memory();
    dn0 = done_log.size();
    @(posedge clk); #1;
    start = 1'b1;
    c0 = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    k      = 3;
    span   = 4;
    target = c0 + 1 + 2 * (HALF + D) + k;
    while (cyc < target) begin
      @(posedge clk); #1;
    end
    abort = 1'b1;
    check_output("abort_stage", 32'(stage), 2);
    check_output("abort_rd_en", 32'(rd_en), 1);
    check_output("abort_rd_addr_a", 32'(rd_addr_a), (k / span) * 2 * span + k % span);
    check_output("abort_rd_addr_b", 32'(rd_addr_b), (k / span) * 2 * span + k % span + span);
    check_output("abort_tw_addr", 32'(tw_addr), (k % span) * (HALF / span));
    @(posedge clk); #1;
    abort = 1'b0;
    flush_req++;
    wr0 = wr_cnt;
    check_output("abort_busy", 32'(busy), 0);
    check_output("abort_rd_en_after", 32'(rd_en), 0);
    repeat (20) begin
      @(posedge clk); #1;
    end
    check_output("abort_wr_after", wr_cnt - wr0, 0);
    check_output("abort_no_done", done_log.size() - dn0, 0);
  endtask

  task automatic idle_start_abort();
    @(posedge clk); #1;
    start = 1'b1;
    abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    abort = 1'b0;
    check_output("start_abort_busy", 32'(busy), 0);
    check_output("start_abort_rd_en", 32'(rd_en), 0);
    check_output("start_abort_stage", 32'(stage), 2);
    @(posedge clk); #1;
    check_output("start_abort_busy2", 32'(busy), 0);
  endtask

  task automatic reset_mid_run();
    int wr0;
    load_memory();
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat ($urandom_range(3, 25)) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("mid_reset");
    flush_req++;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    wr0 = wr_cnt;
    repeat (10) begin
      @(posedge clk); #1;
      check_output("post_reset_wr_en", 32'(wr_en), 0);
      check_output("post_reset_busy", 32'(busy), 0);
    end
    check_output("post_reset_wr_count", wr_cnt - wr0, 0);
  endtask

  initial begin
    $display("[TB] start: LOG2N=%0d RD_LAT=%0d BFLY_LAT=%0d", LOG2N, RD_LAT, BFLY_LAT);
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst_n = 1'b1;
    run_fft(1'b0);
    run_fft(1'b1);
    abort_run();
    idle_start_abort();
    reset_mid_run();
    run_fft(1'b0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
